// File: rtl/fixed_point_adder.sv
// Registered signed-magnitude fixed-point adder with magnitude saturation.
// One operand pair is accepted per cycle; the result appears one clock later.
module fixed_point_adder #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic             out_valid,
    output logic             overflow
);

    localparam int MW = WIDTH - 1;

    // Fraction bits need no special handling because magnitudes add exactly;
    // FRAC only has to describe a legal format.
    generate
        if (WIDTH < 3 || FRAC < 0 || FRAC > WIDTH - 2) begin : g_bad_params
            $error("fixed_point_adder: illegal WIDTH/FRAC combination");
        end
    endgenerate

    logic          sa, sb;
    logic [MW-1:0] ma, mb;
    logic [MW:0]   sum;
    logic [MW-1:0] res_mag;
    logic          res_sign;
    logic          res_ovf;

    logic [WIDTH-1:0] c_d, c_q;
    logic             out_valid_d, out_valid_q;
    logic             overflow_d, overflow_q;

    assign sa  = a[WIDTH-1];
    assign sb  = b[WIDTH-1];
    assign ma  = a[MW-1:0];
    assign mb  = b[MW-1:0];
    assign sum = {1'b0, ma} + {1'b0, mb};

    always_comb begin
        res_mag  = '0;
        res_sign = 1'b0;
        res_ovf  = 1'b0;
        if (sa == sb) begin
            res_sign = sa;
            if (sum[MW]) begin
                res_mag = '1;
                res_ovf = 1'b1;
            end else begin
                res_mag = sum[MW-1:0];
            end
        end else if (ma >= mb) begin
            res_mag  = ma - mb;
            res_sign = sa;
        end else begin
            res_mag  = mb - ma;
            res_sign = sb;
        end
        // A zero magnitude is always reported as positive zero.
        if (res_mag == '0) begin
            res_sign = 1'b0;
        end
    end

    always_comb begin
        c_d         = c_q;
        overflow_d  = overflow_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            c_d        = {res_sign, res_mag};
            overflow_d = res_ovf;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            c_q         <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            c_q         <= c_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign c         = c_q;
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_fixed_point_adder.sv
// Directed self-checking bench for fixed_point_adder (default 16-bit, 8 fraction bits).
module tb_fixed_point_adder;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        in_valid;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [15:0] c;
    logic        out_valid;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    fixed_point_adder #(.WIDTH(16), .FRAC(8)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .in_valid  (in_valid),
        .a         (op_a),
        .b         (op_b),
        .c         (c),
        .out_valid (out_valid),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Drive one operand pair at the falling edge, then sample just after the rising edge.
    task automatic applyStimulus(input logic v, input logic [15:0] va, input logic [15:0] vb);
        @(negedge clk);
        in_valid = v;
        op_a     = va;
        op_b     = vb;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] exp_c,
                               input logic exp_v, input logic exp_o);
        checks++;
        assert (c === exp_c) else begin
            errors++;
            $error("[TB] FAIL %s c: got %h expected %h", tag, c, exp_c);
        end
        checks++;
        assert (out_valid === exp_v) else begin
            errors++;
            $error("[TB] FAIL %s out_valid: got %b expected %b", tag, out_valid, exp_v);
        end
        checks++;
        assert (overflow === exp_o) else begin
            errors++;
            $error("[TB] FAIL %s overflow: got %b expected %b", tag, overflow, exp_o);
        end
    endtask

    initial begin
        n_rst    = 1'b0;
        in_valid = 1'b1;
        op_a     = 16'h0200;
        op_b     = 16'h0100;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_hold", 16'h0000, 1'b0, 1'b0);

        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("first_capture", 16'h0300, 1'b1, 1'b0);

        applyStimulus(1'b1, 16'h0200, 16'h0100); checkOutput("p2_p1", 16'h0300, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'h8200, 16'h0100); checkOutput("m2_p1", 16'h8100, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'h0200, 16'h8100); checkOutput("p2_m1", 16'h0100, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'h8200, 16'h8100); checkOutput("m2_m1", 16'h8300, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'h0100, 16'h8300); checkOutput("p1_m3", 16'h8200, 1'b1, 1'b0);

        applyStimulus(1'b1, 16'h0180, 16'h8180); checkOutput("cancel", 16'h0000, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'h0040, 16'h80C0); checkOutput("frac", 16'h8080, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'h8000, 16'h0000); checkOutput("negzero", 16'h0000, 1'b1, 1'b0);

        applyStimulus(1'b1, 16'h7F00, 16'h00FF); checkOutput("max_exact", 16'h7FFF, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'h7F00, 16'h0200); checkOutput("sat_pos", 16'h7FFF, 1'b1, 1'b1);
        applyStimulus(1'b1, 16'hFF00, 16'h8200); checkOutput("sat_neg", 16'hFFFF, 1'b1, 1'b1);

        applyStimulus(1'b0, 16'h0123, 16'h0456); checkOutput("gate1", 16'hFFFF, 1'b0, 1'b1);
        applyStimulus(1'b0, 16'h0789, 16'h0001); checkOutput("gate2", 16'hFFFF, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h0100, 16'h0100); checkOutput("ovf_clear", 16'h0200, 1'b1, 1'b0);

        // Asynchronous reset between clock edges discards the held result.
        applyStimulus(1'b1, 16'h0300, 16'h0100); checkOutput("pre_reset", 16'h0400, 1'b1, 1'b0);
        #2;
        n_rst = 1'b0;
        #1;
        checkOutput("async_reset", 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        n_rst    = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_reset_idle", 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h8040, 16'h0040); checkOutput("post_reset_add", 16'h0000, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fixed_point_adder.md
Name: fixed_point_adder

Overview:
- Registered signed-magnitude fixed-point adder: sums two words and presents the result one clock later with a valid flag.
- Number format: bit [W-1] is the sign (1 = negative), bits [W-2:F] are the integer magnitude, bits [F-1:0] are the fraction magnitude.
- Default is 16-bit with 8 fraction bits, so 2.0 = 0x0200 and -1.0 = 0x8100.
- Used as the adder primitive in the FFT butterfly datapath.

Parameters:
- WIDTH, 16, total word width including sign bit (>= 3).
- FRAC, 8, number of fraction bits (0 <= FRAC <= WIDTH-2).

Ports:
- clk  in  1  rising-edge clock.
- n_rst  in  1  asynchronous active-low reset.
- in_valid  in  1  operands a/b are valid this cycle.
- a  in  WIDTH  operand A, signed-magnitude.
- b  in  WIDTH  operand B, signed-magnitude.
- c  out  WIDTH  registered sum, signed-magnitude.
- out_valid  out  1  c is valid; registered copy of in_valid.
- overflow  out  1  registered flag: the magnitude saturated on this result.

Behaviour:
- Reset: while n_rst = 0, c = 0, out_valid = 0 and overflow = 0, asynchronously.
  - Reset asserted mid-operation discards any pending result.
  - First capture occurs on the first rising edge after n_rst deasserts.
- Latency is exactly 1 cycle.
  - On each rising edge with in_valid = 1, the result of a+b loads into c and overflow, and out_valid becomes 1.
  - On each rising edge with in_valid = 0, out_valid becomes 0 while c and overflow hold their previous values.
- No backpressure: a new operand pair is accepted every cycle (full throughput).
- Arithmetic on magnitudes ma = a[W-2:0] and mb = b[W-2:0], with signs sa and sb:
  - sa == sb: sum = ma + mb computed W bits wide; result sign = sa.
    - If sum > 2^(W-1)-1, the magnitude saturates to all ones (0x7FFF for the default) and overflow = 1.
  - sa != sb: the result magnitude is |ma - mb| and its sign is the sign of the larger magnitude. No overflow is possible.
  - Equal magnitudes with opposite signs give +0 (c = 0).
- Negative zero (sign = 1, magnitude = 0) is accepted as an input and treated as zero.
- The output never produces negative zero: a zero magnitude always has sign 0.
- Fraction bits are added exactly; there is no rounding or truncation.
- overflow applies only to the result it accompanies.
- The combinational path from a/b to the register is a single adder/subtractor with a magnitude compare. There are no other pipeline stages.

Test Plan:
- Reset: hold n_rst = 0 with in_valid = 1, a = 0x0200 -> c = 0x0000, out_valid = 0, overflow = 0. Deassert n_rst and clock once -> c = 0x0200 + b.
- Signs, one pair per cycle back-to-back:
  - 2+1: 0x0200 + 0x0100 -> 0x0300.
  - -2+1: 0x8200 + 0x0100 -> 0x8100.
  - 2+-1: 0x0200 + 0x8100 -> 0x0100.
  - -2+-1: 0x8200 + 0x8100 -> 0x8300.
  - Each result appears 1 cycle after its inputs with out_valid = 1 and overflow = 0.
- Fractions and cancellation:
  - 1.5 + -1.5: 0x0180 + 0x8180 -> 0x0000 (positive zero).
  - 0.25 + -0.75: 0x0040 + 0x80C0 -> 0x8080.
  - -0 + 0: 0x8000 + 0x0000 -> 0x0000.
- Saturation:
  - 0x7F00 + 0x0200 -> 0x7FFF, overflow = 1.
  - 0xFF00 + 0x8200 -> 0xFFFF, overflow = 1.
  - The next non-overflowing add (e.g. 0x0100 + 0x0100 -> 0x0200) clears overflow.
- Valid gating: drop in_valid for 2 cycles while changing a/b -> out_valid = 0 and c holds its last value. Raising in_valid again -> new result after 1 cycle.
